// File: rtl/core_l1d_resp.sv
// core_l1d_resp: data-side responder for the core's L1D request port.
//
// Accepts one load/store at a time and turns it into a single word-aligned,
// byte-enabled memory bus transaction. It returns a one-cycle acknowledge
// carrying either zero-extended, right-justified load data or an error flag.
// The error flag covers a misaligned access, an illegal size or a timeout.
//
// Parameters
//   TIMEOUT  max cycles spent in REQ+WAIT before an error response (0 = off)
//   TW       width of the timeout counter, TIMEOUT < 2**TW
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   l1d_req_*         request from execute/memory stage (val/rdy handshake)
//   l1d_ack/err/rdata one-cycle completion with data or error
//   mem_req_*         memory request (val/ack handshake), held stable in REQ
//   mem_resp_*        memory response (reads and writes)
//
// All outputs are decoded from registered state only.

module core_l1d_resp #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TW      = 8
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        l1d_req_val,
    output logic        l1d_req_rdy,
    input  logic        l1d_req_cop,
    input  logic [2:0]  l1d_req_size,
    input  logic [31:0] l1d_req_addr,
    input  logic [31:0] l1d_req_wdata,
    output logic        l1d_ack,
    output logic [31:0] l1d_rdata,
    output logic        l1d_err,

    output logic        mem_req_val,
    input  logic        mem_req_ack,
    output logic        mem_req_we,
    output logic [31:0] mem_req_addr,
    output logic [3:0]  mem_req_be,
    output logic [31:0] mem_req_wdata,
    input  logic        mem_resp_val,
    input  logic [31:0] mem_resp_data
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

    localparam logic [2:0] SzByte = 3'b001;
    localparam logic [2:0] SzHalf = 3'b010;
    localparam logic [2:0] SzWord = 3'b100;

    state_e        state_q, state_d;
    logic          cop_q, cop_d;
    logic [2:0]    size_q, size_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          req_bad;
    logic          timeout_hit;
    logic [31:0]   resp_shifted;
    logic [31:0]   load_data;
    logic [3:0]    be_dec;
    logic [31:0]   wdata_dec;
    logic          in_req;

    // Illegal size or natural misalignment of the incoming request.
    always_comb begin
        req_bad = 1'b0;
        case (l1d_req_size)
            SzByte:  req_bad = 1'b0;
            SzHalf:  req_bad = l1d_req_addr[0];
            SzWord:  req_bad = (l1d_req_addr[1:0] != 2'b00);
            default: req_bad = 1'b1;
        endcase
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TW'(TIMEOUT));

    // Load lane select: shift the addressed lane to bit 0, zero-fill above.
    assign resp_shifted = mem_resp_data >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_data = 32'h0;
        if (!cop_q) begin
            case (size_q)
                SzByte:  load_data = {24'h0, resp_shifted[7:0]};
                SzHalf:  load_data = {16'h0, resp_shifted[15:0]};
                default: load_data = resp_shifted;
            endcase
        end
    end

    always_comb begin
        be_dec    = 4'b0000;
        wdata_dec = 32'h0;
        case (size_q)
            SzByte: begin
                be_dec    = 4'b0001 << addr_q[1:0];
                wdata_dec = {4{wdata_q[7:0]}};
            end
            SzHalf: begin
                be_dec    = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_dec = {2{wdata_q[15:0]}};
            end
            SzWord: begin
                be_dec    = 4'b1111;
                wdata_dec = wdata_q;
            end
            default: begin
                be_dec    = 4'b0000;
                wdata_dec = 32'h0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cop_d   = cop_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;

        case (state_q)
            StIdle: begin
                if (l1d_req_val) begin
                    cop_d   = l1d_req_cop;
                    size_d  = l1d_req_size;
                    addr_d  = l1d_req_addr;
                    wdata_d = l1d_req_wdata;
                    rdata_d = 32'h0;
                    cnt_d   = '0;
                    if (req_bad) begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        err_d   = 1'b0;
                        state_d = StReq;
                    end
                end
            end
            // A timeout wins over a coincident ack/response: the transaction
            // is abandoned and the memory side must tolerate that.
            StReq: begin
                cnt_d = cnt_q + TW'(1);
                if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = StResp;
                end else if (mem_req_ack) begin
                    if (mem_resp_val) begin
                        rdata_d = load_data;
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q + TW'(1);
                if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = StResp;
                end else if (mem_resp_val) begin
                    rdata_d = load_data;
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cop_q   <= 1'b0;
            size_q  <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cop_q   <= cop_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign in_req = (state_q == StReq);

    assign l1d_req_rdy   = (state_q == StIdle);
    assign l1d_ack       = (state_q == StResp);
    assign l1d_err       = l1d_ack & err_q;
    assign l1d_rdata     = l1d_ack ? rdata_q : 32'h0;

    // Bus fields are driven only while the request is presented.
    assign mem_req_val   = in_req;
    assign mem_req_we    = in_req & cop_q;
    assign mem_req_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_req_be    = in_req ? be_dec : 4'b0000;
    assign mem_req_wdata = in_req ? wdata_dec : 32'h0;

endmodule

// File: tb/tb_core_l1d_resp.sv
// Self-checking bench for core_l1d_resp: directed cases followed by random
// transactions, each checked cycle by cycle against a transaction-level model.

module tb_core_l1d_resp;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        l1d_req_val;
    logic        l1d_req_rdy;
    logic        l1d_req_cop;
    logic [2:0]  l1d_req_size;
    logic [31:0] l1d_req_addr;
    logic [31:0] l1d_req_wdata;
    logic        l1d_ack;
    logic [31:0] l1d_rdata;
    logic        l1d_err;
    logic        mem_req_val;
    logic        mem_req_ack;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [3:0]  mem_req_be;
    logic [31:0] mem_req_wdata;
    logic        mem_resp_val;
    logic [31:0] mem_resp_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    core_l1d_resp #(
        .TIMEOUT(TO),
        .TW     (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .l1d_req_val  (l1d_req_val),
        .l1d_req_rdy  (l1d_req_rdy),
        .l1d_req_cop  (l1d_req_cop),
        .l1d_req_size (l1d_req_size),
        .l1d_req_addr (l1d_req_addr),
        .l1d_req_wdata(l1d_req_wdata),
        .l1d_ack      (l1d_ack),
        .l1d_rdata    (l1d_rdata),
        .l1d_err      (l1d_err),
        .mem_req_val  (mem_req_val),
        .mem_req_ack  (mem_req_ack),
        .mem_req_we   (mem_req_we),
        .mem_req_addr (mem_req_addr),
        .mem_req_be   (mem_req_be),
        .mem_req_wdata(mem_req_wdata),
        .mem_resp_val (mem_resp_val),
        .mem_resp_data(mem_resp_data)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] size);
        case (size)
            3'b001:  return 1;
            3'b010:  return 2;
            3'b100:  return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit is_bad(input logic [2:0] size, input logic [31:0] addr);
        int n = nbytes(size);
        if (n == 0) return 1'b1;
        return (int'(addr[1:0]) % n) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] size, input logic [31:0] addr);
        logic [3:0] be = 4'b0000;
        int off = int'(addr[1:0]);
        int n = nbytes(size);
        for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + n);
        return be;
    endfunction

    function automatic logic [31:0] model_lanes(input logic [2:0] size, input logic [31:0] wd);
        logic [31:0] v = 32'h0;
        int n = nbytes(size);
        for (int i = 0; i < 4; i++) v[8*i +: 8] = wd[8*(i % n) +: 8];
        return v;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] size, input logic [31:0] addr,
                                               input logic [31:0] word);
        logic [31:0] v = 32'h0;
        int off = int'(addr[1:0]);
        int n = nbytes(size);
        for (int i = 0; i < n; i++) v[8*i +: 8] = word[8*(off + i) +: 8];
        return v;
    endfunction

    // One transaction. The memory acks in REQ cycle a+1 (cycle 1 = first cycle
    // after the accept edge) and responds r cycles after its ack.
    task automatic run_txn(input logic cop, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input int a, input int r,
                           input logic [31:0] rword);
        bit          bad = is_bad(size, addr);
        int          lat, reqcyc, t_end;
        logic        eerr;
        logic [31:0] erd;
        if (bad) begin
            lat = 1; eerr = 1'b1; erd = 32'h0; reqcyc = 0; t_end = 2;
        end else begin
            reqcyc = ((a < int'(TO)) ? a : int'(TO)) + 1;
            if (a + r < int'(TO)) begin
                lat  = a + r + 2;
                eerr = 1'b0;
                erd  = cop ? 32'h0 : model_load(size, addr, rword);
            end else begin
                lat  = int'(TO) + 2;
                eerr = 1'b1;
                erd  = 32'h0;
            end
            t_end = (lat + 1 > a + r + 1) ? lat + 1 : a + r + 1;
        end

        @(negedge clk);
        check_eq("rdy_before_accept", l1d_req_rdy, 1'b1);
        mem_req_ack   = 1'b0;
        mem_resp_val  = 1'b0;
        l1d_req_val   = 1'b1;
        l1d_req_cop   = cop;
        l1d_req_size  = size;
        l1d_req_addr  = addr;
        l1d_req_wdata = wdata;

        for (int t = 1; t <= t_end; t++) begin
            @(negedge clk);
            if (t == 1) begin
                l1d_req_val   = 1'b0;
                l1d_req_cop   = 1'($urandom);
                l1d_req_size  = 3'($urandom);
                l1d_req_addr  = $urandom;
                l1d_req_wdata = $urandom;
            end
            check_eq("l1d_ack", l1d_ack, (t == lat));
            if (t == lat) begin
                check_eq("l1d_err", l1d_err, eerr);
                check_eq("l1d_rdata", l1d_rdata, erd);
            end
            check_eq("l1d_req_rdy", l1d_req_rdy, (t > lat));
            check_eq("mem_req_val", mem_req_val, (t <= reqcyc));
            if (t <= reqcyc) begin
                check_eq("mem_req_addr", mem_req_addr, {addr[31:2], 2'b00});
                check_eq("mem_req_be", mem_req_be, model_be(size, addr));
                check_eq("mem_req_we", mem_req_we, cop);
                if (cop) check_eq("mem_req_wdata", mem_req_wdata, model_lanes(size, wdata));
            end
            mem_req_ack   = !bad && (t == a + 1);
            mem_resp_val  = !bad && (t == a + r + 1);
            mem_resp_data = (t == a + r + 1) ? rword : $urandom;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rdy"}, l1d_req_rdy, 1'b1);
        check_eq({tag, "_ack"}, l1d_ack, 1'b0);
        check_eq({tag, "_err"}, l1d_err, 1'b0);
        check_eq({tag, "_rdata"}, l1d_rdata, 32'h0);
        check_eq({tag, "_mval"}, mem_req_val, 1'b0);
        check_eq({tag, "_mwe"}, mem_req_we, 1'b0);
        check_eq({tag, "_maddr"}, mem_req_addr, 32'h0);
        check_eq({tag, "_mbe"}, mem_req_be, 4'h0);
        check_eq({tag, "_mwdata"}, mem_req_wdata, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        l1d_req_val   = 1'b0;
        l1d_req_cop   = 1'b0;
        l1d_req_size  = 3'b000;
        l1d_req_addr  = 32'h0;
        l1d_req_wdata = 32'h0;
        mem_req_ack   = 1'b0;
        mem_resp_val  = 1'b0;
        mem_resp_data = 32'h0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Directed cases.
        run_txn(1'b0, 3'b100, 32'h0000_0100, $urandom, 0, 1, 32'hDEAD_BEEF);
        run_txn(1'b0, 3'b001, 32'h0000_0103, $urandom, 0, 1, 32'hAABB_CCDD);
        run_txn(1'b0, 3'b010, 32'h0000_0102, $urandom, 0, 1, 32'hAABB_CCDD);
        run_txn(1'b1, 3'b010, 32'h0000_0102, 32'h0000_1234, 0, 1, $urandom);
        run_txn(1'b0, 3'b100, 32'h0000_0101, $urandom, 0, 1, $urandom);
        run_txn(1'b0, 3'b011, 32'h0000_0100, $urandom, 0, 1, $urandom);
        run_txn(1'b0, 3'b100, 32'h0000_0200, $urandom, 0, 0, 32'h1357_9BDF);
        // Never acked in time: acks and responds only once back in IDLE.
        run_txn(1'b0, 3'b100, 32'h0000_0300, $urandom, 9, 0, 32'hFFFF_FFFF);

        // Reset while in WAIT.
        @(negedge clk);
        l1d_req_val  = 1'b1;
        l1d_req_cop  = 1'b0;
        l1d_req_size = 3'b100;
        l1d_req_addr = 32'h0000_0400;
        @(negedge clk);
        l1d_req_val = 1'b0;
        mem_req_ack = 1'b1;
        @(negedge clk);
        mem_req_ack = 1'b0;
        check_eq("wait_mval", mem_req_val, 1'b0);
        check_eq("wait_rdy", l1d_req_rdy, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        rst_n         = 1'b1;
        mem_resp_val  = 1'b1;
        mem_resp_data = 32'h1111_2222;
        @(negedge clk);
        mem_resp_val = 1'b0;
        check_eq("post_reset_ack", l1d_ack, 1'b0);
        check_eq("post_reset_rdy", l1d_req_rdy, 1'b1);
        run_txn(1'b0, 3'b100, 32'h0000_0500, $urandom, 1, 1, 32'hCAFE_F00D);

        // Random transactions.
        for (int k = 0; k < 200; k++) begin
            logic        cop  = 1'($urandom);
            int          sel  = int'($urandom_range(0, 9));
            logic [2:0]  size;
            logic [31:0] addr = $urandom;
            int          n;
            if (sel == 0)      size = 3'($urandom);
            else if (sel <= 3) size = 3'b001;
            else if (sel <= 6) size = 3'b010;
            else               size = 3'b100;
            n = nbytes(size);
            if (n != 0 && $urandom_range(0, 3) != 0) addr = addr & ~32'(n - 1);
            run_txn(cop, size, addr, $urandom, int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 4)), $urandom);
        end

        @(negedge clk);
        mem_req_ack  = 1'b0;
        mem_resp_val = 1'b0;
        check_eq("final_rdy", l1d_req_rdy, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
